// File: rtl/shift_norm.sv
// Multi-cycle leading-zero normaliser: binary-search reduction, one stage per cycle.
// Optional NORM_EARLY_EXIT_EN: zero or already-normalised operands skip the search (IDLE -> DONE).
module shift_norm #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_src,
  input  logic             in_word32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic [XLEN-1:0]  out_norm,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;   // stage width = 32 >> step
  logic [XLEN-1:0]  work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             w32_q, w32_d;

  logic             accept, done;
  logic [XLEN-1:0]  ld_work, top_mask;
  logic [6:0]       stg_w;

  assign accept   = in_valid && (state_q == IDLE) && !flush;
  assign ld_work  = in_word32 ? {in_src[31:0], {(XLEN-32){1'b0}}} : in_src;
  assign stg_w    = 7'd32 >> step_q;
  assign top_mask = ~({XLEN{1'b1}} >> stg_w);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    w32_d   = w32_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = ld_work;
          cnt_d   = '0;
          zero_d  = (ld_work == '0);
          w32_d   = in_word32;
          step_d  = in_word32 ? 3'd1 : 3'd0;
          state_d = RUN;
`ifdef NORM_EARLY_EXIT_EN
          if ((ld_work == '0) || ld_work[XLEN-1]) state_d = DONE;
`endif
        end
      end
      RUN: begin
        if ((work_q & top_mask) == '0) begin
          work_d = work_q << stg_w;
          cnt_d  = cnt_q + CNT_W'(stg_w);
        end
        if (step_q == 3'd5) state_d = DONE;
        else                step_d  = step_q + 3'd1;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      step_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      w32_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      w32_q   <= w32_d;
    end
  end

  // Results are gated to DONE so a flushed or in-flight op never leaks out.
  assign done      = (state_q == DONE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = done;
  assign out_zero  = done && zero_q;

  always_comb begin
    out_cnt  = '0;
    out_norm = '0;
    if (done) begin
      if (zero_q) begin
        out_cnt = w32_q ? CNT_W'(32) : CNT_W'(XLEN);
      end else begin
        out_cnt  = cnt_q;
        out_norm = w32_q ? {{(XLEN-32){1'b0}}, work_q[XLEN-1 -: 32]} : work_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_norm.sv
// Scoreboard bench for shift_norm: reference CLZ model by linear scan, latency/stall/flush/reset checks.
module tb_shift_norm;

  typedef struct {
    logic [6:0]  cnt;
    logic [63:0] norm;
    logic        zero;
    int          lat;
  } exp_t;

  logic        gclk, grst_n;
  logic        flush, in_valid, in_ready, in_word32;
  logic [63:0] in_src;
  logic        out_valid, out_ready, out_zero;
  logic [6:0]  out_cnt;
  logic [63:0] out_norm;

  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];

  shift_norm #(.XLEN(64), .CNT_W(7)) dut (
    .clk(gclk), .rst_n(grst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_word32(in_word32),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt), .out_norm(out_norm), .out_zero(out_zero)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Linear-scan reference; latency counted in edges after the accepting edge.
  function automatic exp_t model(input logic [63:0] src, input logic w32);
    exp_t e;
    int   width;
    logic [63:0] op;
    width = w32 ? 32 : 64;
    op    = w32 ? {32'b0, src[31:0]} : src;
    e.cnt = 7'(width);
    for (int i = 0; i < width; i++)
      if (op[i]) e.cnt = 7'(width - 1 - i);
    e.zero = (op == 64'b0);
    if (e.zero)   e.norm = 64'b0;
    else if (w32) e.norm = {32'b0, op[31:0] << e.cnt};
    else          e.norm = op << e.cnt;
    e.lat = w32 ? 5 : 6;
`ifdef NORM_EARLY_EXIT_EN
    if (e.zero || e.cnt == 7'd0) e.lat = 0;
`endif
    return e;
  endfunction

  task automatic run_op(input logic [63:0] src, input logic w32, input int hold, input string tag);
    exp_t e;
    int   lat;
    logic [6:0]  c0;
    logic [63:0] n0;
    @(negedge gclk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_src = src; in_word32 = w32;
    sb.push_back(model(src, w32));
    @(posedge gclk); #1;
    in_valid = 1'b0; in_src = {$urandom, $urandom}; in_word32 = ~w32;
    lat = 0;
    while (!out_valid && lat < 16) begin
      @(posedge gclk); #1;
      lat++;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".lat"}, 64'(lat), 64'(e.lat));
      chk({tag, ".cnt"}, out_cnt, e.cnt);
      chk({tag, ".norm"}, out_norm, e.norm);
      chk({tag, ".zero"}, out_zero, e.zero);
      chk({tag, ".busy"}, in_ready, 0);
    end
    c0 = out_cnt; n0 = out_norm;
    for (int i = 0; i < hold; i++) begin
      @(posedge gclk); #1;
      chk({tag, ".hold_vld"}, out_valid, 1);
      chk({tag, ".hold_cnt"}, out_cnt, c0);
      chk({tag, ".hold_norm"}, out_norm, n0);
      chk({tag, ".hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge gclk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop_vld"}, out_valid, 0);
    chk({tag, ".back_rdy"}, in_ready, 1);
  endtask

  task automatic accept_and_wait(input logic [63:0] src, input int edges);
    @(negedge gclk);
    in_valid = 1'b1; in_src = src; in_word32 = 1'b0;
    @(posedge gclk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < edges; i++) begin
      @(posedge gclk); #1;
    end
  endtask

  initial begin
    int seen;
    grst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_src = '0; in_word32 = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_cnt", out_cnt, 0);
    chk("rst.out_norm", out_norm, 0);
    chk("rst.out_zero", out_zero, 0);
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;

    run_op(64'h1, 1'b0, 0, "t1");
    run_op(64'hDEAD_BEEF_0001_0000, 1'b1, 0, "t2");
    run_op(64'h0, 1'b0, 0, "t3z64");
    run_op(64'hFFFF_FFFF_0000_0000, 1'b1, 0, "t3z32");
    run_op(64'h0000_0F00_0000_0000, 1'b0, 3, "t4");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "t6a");
    run_op(64'h8, 1'b0, 0, "t6b");
    run_op(64'h0000_0000_8000_0000, 1'b1, 0, "w32top");
    for (int i = 0; i < 8; i++)
      run_op({$urandom, $urandom} >> $urandom_range(0, 63), 1'($urandom_range(0, 1)), i % 2, "rnd");

    // flush asserted before the edge that applies the 3rd RUN stage
    accept_and_wait(64'h1, 2);
    flush = 1'b1;
    @(posedge gclk); #1;
    flush = 1'b0;
    chk("flush.in_ready", in_ready, 1);
    chk("flush.out_valid", out_valid, 0);
    seen = 0;
    repeat (10) begin
      @(posedge gclk); #1;
      if (out_valid) seen++;
    end
    chk("flush.no_result", 64'(seen), 0);

    // flush with a request in IDLE must not accept it
    @(negedge gclk);
    in_valid = 1'b1; flush = 1'b1; in_src = 64'h1;
    @(posedge gclk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle.in_ready", in_ready, 1);

    // async reset mid-operation
    accept_and_wait(64'h1, 2);
    grst_n = 1'b0;
    #1;
    chk("rst_mid.in_ready", in_ready, 1);
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.out_cnt", out_cnt, 0);
    chk("rst_mid.out_norm", out_norm, 0);
    chk("rst_mid.out_zero", out_zero, 0);
    @(negedge gclk);
    grst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge gclk); #1;
      if (out_valid) seen++;
    end
    chk("rst_mid.no_result", 64'(seen), 0);

    run_op(64'h0000_0000_0000_0100, 1'b0, 1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
